// File: rtl/cache_pkg.sv
// Shared definitions for the MEM-stage data cache.
// Holds the mem_cmd encodings, the default cache geometry, the controller
// state enum and a helper that picks one 32-bit word out of a 64-bit line.
package cache_pkg;

    // mem_cmd encodings; 2'b11 is treated like CMD_NONE.
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;

    // Default geometry: 64 sets, 19 address bits, 8-byte lines.
    localparam int SET_BITS  = 6;
    localparam int ADDR_BITS = 19;
    localparam int TAG_W     = ADDR_BITS - 3 - SET_BITS;
    localparam int LINE_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Lines are stored as {word1, word0}; off selects the word.
    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic off);
        return off ? line[LINE_W-1:32] : line[31:0];
    endfunction

endpackage

// File: rtl/mem_stage_cache_if.sv
// Pipeline-side bus of the MEM-stage cache.
//   mem_cmd, addr, wdata : request from the EXE/MEM register (master drives)
//   rdata, ready         : completion toward MEM/WB (cache drives)
//   state                : controller state, exported for observation
//
// Handshake: a request is present whenever mem_cmd is CMD_LOAD or CMD_STORE.
// The master holds mem_cmd, addr and wdata stable while ready=0; the request
// completes in the cycle where ready=1, and the master may present a new
// request in the following cycle. With no request, ready is 1.
interface mem_stage_cache_if;
    import cache_pkg::*;

    logic [1:0]  mem_cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    state_t      state;

    modport master (output mem_cmd, addr, wdata, input rdata, ready, state);
    modport slave  (input mem_cmd, addr, wdata, output rdata, ready, state);

endinterface

// File: rtl/cache_array.sv
// Storage for a 2-way set-associative cache: per way valid/tag/data, per set
// one LRU bit naming the next victim way.
//   clk, rst    : clock, asynchronous active-high reset (clears valid + LRU)
//   index       : set index, shared by the asynchronous read and the write
//   way_valid/way_tag/way_data/lru : asynchronous read of the indexed set
//   wr_way      : way targeted by line_we or word_we
//   line_we     : write whole line (tag, data, valid<-1)
//   word_we     : overwrite one 32-bit word (word_off selects it)
//   lru_we/lru_val : update the indexed set's LRU bit
module cache_array #(
    parameter int SET_BITS = 6,
    parameter int TAG_W    = 10,
    parameter int LINE_W   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SET_BITS-1:0]          index,
    output logic [1:0]                   way_valid,
    output logic [1:0][TAG_W-1:0]        way_tag,
    output logic [1:0][LINE_W-1:0]       way_data,
    output logic                         lru,
    input  logic                         wr_way,
    input  logic                         line_we,
    input  logic [TAG_W-1:0]             line_tag,
    input  logic [LINE_W-1:0]            line_data,
    input  logic                         word_we,
    input  logic                         word_off,
    input  logic [LINE_W/2-1:0]          word_data,
    input  logic                         lru_we,
    input  logic                         lru_val
);
    localparam int SETS = 1 << SET_BITS;
    localparam int HALF = LINE_W / 2;

    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_mem  [2][SETS];
    logic [LINE_W-1:0]    data_mem [2][SETS];

    // Control bits are reset; tag/data contents are only meaningful when valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (line_we) valid_q[wr_way][index] <= 1'b1;
            if (lru_we)  lru_q[index] <= lru_val;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[wr_way][index]  <= line_tag;
            data_mem[wr_way][index] <= line_data;
        end else if (word_we) begin
            if (word_off) data_mem[wr_way][index][LINE_W-1:HALF] <= word_data;
            else          data_mem[wr_way][index][HALF-1:0]      <= word_data;
        end
    end

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_valid[w] = valid_q[w][index];
            way_tag[w]   = tag_mem[w][index];
            way_data[w]  = data_mem[w][index];
        end
        lru = lru_q[index];
    end

endmodule

// File: rtl/mem_stage_cache.sv
// MEM-stage data cache controller: 2-way set-associative, write-through,
// no-write-allocate, backed by an SRAM controller with 64-bit line reads and
// 32-bit word writes.
//   clk, rst   : pipeline clock, asynchronous active-high reset
//   pipe       : pipeline request/response bus (mem_cmd, addr, wdata, rdata,
//                ready, state)
//   sram_addr  : SRAM word address addr[18:2] (bit 0 ignored on line reads)
//   sram_wdata : store data
//   sram_re    : line read request, held until sram_ready
//   sram_we    : word write request, held until sram_ready
//   sram_rdata : line data {word1, word0}
//   sram_ready : one-cycle completion pulse for the outstanding request
module mem_stage_cache #(
    parameter int SET_BITS  = cache_pkg::SET_BITS,
    parameter int ADDR_BITS = cache_pkg::ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_stage_cache_if.slave      pipe,
    output logic [ADDR_BITS-3:0]  sram_addr,
    output logic [31:0]           sram_wdata,
    output logic                  sram_re,
    output logic                  sram_we,
    input  logic [63:0]           sram_rdata,
    input  logic                  sram_ready
);
    import cache_pkg::*;

    localparam int TAG_BITS = ADDR_BITS - 3 - SET_BITS;

    state_t state_q, state_d;

    logic                  offset;
    logic [SET_BITS-1:0]   index;
    logic [TAG_BITS-1:0]   tag;

    logic [1:0]                  way_valid;
    logic [1:0][TAG_BITS-1:0]    way_tag;
    logic [1:0][LINE_W-1:0]      way_data;
    logic                        set_lru;

    logic hit0, hit1, hit, hit_way, victim;
    logic wr_way, line_we, word_we, lru_we, lru_val;

    assign offset = pipe.addr[2];
    assign index  = pipe.addr[SET_BITS+2:3];
    assign tag    = pipe.addr[ADDR_BITS-1:SET_BITS+3];

    // Byte-lane bits and address bits above the cached range carry no meaning.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pipe.addr[31:ADDR_BITS], pipe.addr[1:0]};

    cache_array #(
        .SET_BITS (SET_BITS),
        .TAG_W    (TAG_BITS),
        .LINE_W   (LINE_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .way_valid (way_valid),
        .way_tag   (way_tag),
        .way_data  (way_data),
        .lru       (set_lru),
        .wr_way    (wr_way),
        .line_we   (line_we),
        .line_tag  (tag),
        .line_data (sram_rdata),
        .word_we   (word_we),
        .word_off  (offset),
        .word_data (pipe.wdata),
        .lru_we    (lru_we),
        .lru_val   (lru_val)
    );

    assign hit0    = way_valid[0] && (way_tag[0] == tag);
    assign hit1    = way_valid[1] && (way_tag[1] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = ~hit0;
    // Fill empty ways first (way0 before way1); only then follow LRU.
    assign victim  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : set_lru);

    assign sram_addr  = pipe.addr[ADDR_BITS-1:2];
    assign sram_wdata = pipe.wdata;
    assign pipe.state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // While rst is high everything stays at its idle value so the request
    // lines drop immediately and ready reads 1 regardless of mem_cmd.
    always_comb begin
        state_d    = state_q;
        pipe.ready = 1'b1;
        pipe.rdata = '0;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        wr_way     = 1'b0;
        line_we    = 1'b0;
        word_we    = 1'b0;
        lru_we     = 1'b0;
        lru_val    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (pipe.mem_cmd == CMD_LOAD) begin
                        if (hit) begin
                            pipe.rdata = line_word(way_data[hit_way], offset);
                            lru_we     = 1'b1;
                            lru_val    = ~hit_way;
                        end else begin
                            pipe.ready = 1'b0;
                            state_d    = FILL;
                        end
                    end else if (pipe.mem_cmd == CMD_STORE) begin
                        pipe.ready = 1'b0;
                        state_d    = WRITE;
                        // Write-through: a hit updates the cached copy now,
                        // the SRAM write follows; a miss allocates nothing.
                        if (hit) begin
                            word_we = 1'b1;
                            wr_way  = hit_way;
                            lru_we  = 1'b1;
                            lru_val = ~hit_way;
                        end
                    end
                end
                FILL: begin
                    sram_re    = 1'b1;
                    pipe.ready = 1'b0;
                    if (sram_ready) begin
                        // Forward the critical word in the same cycle the
                        // line arrives, and install the line at the edge.
                        pipe.ready = 1'b1;
                        pipe.rdata = line_word(sram_rdata, offset);
                        line_we    = 1'b1;
                        wr_way     = victim;
                        lru_we     = 1'b1;
                        lru_val    = ~victim;
                        state_d    = IDLE;
                    end
                end
                WRITE: begin
                    sram_we    = 1'b1;
                    pipe.ready = sram_ready;
                    if (sram_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_cache.sv
// Bench for mem_stage_cache: table of pipeline operations driven through a
// small SRAM responder, with expected load data queued at issue and checked
// when the cache completes, plus hand-written reset and idle sequences.
module tb_mem_stage_cache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_re;
    logic        sram_we;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    mem_stage_cache_if pipe();

    mem_stage_cache dut (
        .clk        (clk),
        .rst        (rst),
        .pipe       (pipe),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [logic [16:0]];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SRAM contents: explicitly written words, otherwise a pattern of the address.
    function automatic logic [31:0] ref_rd(input logic [16:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return 32'hC0DE0000 | {15'b0, wa};
    endfunction

    // ---------------- driver ----------------
    // Presents one command and services the SRAM: sram_ready pulses in the
    // delay-th cycle of the request. Starts and ends on a falling edge.
    task automatic run_op(input string nm, input logic [1:0] cmd, input logic [31:0] a,
                          input logic [31:0] wd, input int delay,
                          output bit saw_re, output bit saw_we, output int cycles);
        int          rc;
        bit          done;
        logic [16:0] wa;
        logic [31:0] exp_d;
        wa     = a[18:2];
        rc     = 0;
        done   = 1'b0;
        saw_re = 1'b0;
        saw_we = 1'b0;
        cycles = 0;
        pipe.mem_cmd = cmd;
        pipe.addr    = a;
        pipe.wdata   = wd;
        if (cmd == CMD_LOAD) exp_q.push_back(ref_rd(wa));
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            sram_ready = 1'b0;
            sram_rdata = {$urandom, $urandom};
            if (sram_re || sram_we) begin
                rc++;
                if (rc == delay) begin
                    sram_ready = 1'b1;
                    sram_rdata = {ref_rd({wa[16:1], 1'b1}), ref_rd({wa[16:1], 1'b0})};
                    if (sram_we) ref_mem[wa] = wd;
                end
            end
            #1;
            cycles++;
            check({nm, " re_we_exclusive"}, 64'(sram_re & sram_we), 64'd0);
            if (sram_re) begin
                saw_re = 1'b1;
                check({nm, " read_addr"}, 64'(sram_addr), 64'(wa));
            end
            if (sram_we) begin
                saw_we = 1'b1;
                check({nm, " write_addr"}, 64'(sram_addr), 64'(wa));
                check({nm, " write_data"}, 64'(sram_wdata), 64'(wd));
            end
            if (pipe.ready) begin
                done = 1'b1;
                if (cmd == CMD_LOAD) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL %s rdata: got %0h with no expected value queued", nm, pipe.rdata);
                    end else begin
                        exp_d = exp_q.pop_front();
                        check({nm, " rdata"}, 64'(pipe.rdata), 64'(exp_d));
                    end
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: ready=0 after 64 cycles, required 1", nm);
        end
        @(negedge clk);
        pipe.mem_cmd = CMD_NONE;
        sram_ready   = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] a;
        logic [31:0] wd;
        int          delay;
        bit          exp_re;
        bit          exp_we;
        int          exp_cycles;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        bit saw_re, saw_we;
        int cycles;

        // Fill, hit on the other word, store hit, store miss, LRU eviction.
        vecs[0]  = '{CMD_LOAD,  32'h0000_0040, 32'h0,         3, 1'b1, 1'b0, 4};
        vecs[1]  = '{CMD_LOAD,  32'h0000_0044, 32'h0,         1, 1'b0, 1'b0, 1};
        vecs[2]  = '{CMD_STORE, 32'h0000_0044, 32'hDEADBEEF,  2, 1'b0, 1'b1, 3};
        vecs[3]  = '{CMD_LOAD,  32'h0000_0044, 32'h0,         1, 1'b0, 1'b0, 1};
        vecs[4]  = '{CMD_STORE, 32'h0000_0200, 32'h12345678,  1, 1'b0, 1'b1, 2};
        vecs[5]  = '{CMD_LOAD,  32'h0000_0200, 32'h0,         2, 1'b1, 1'b0, 3};
        vecs[6]  = '{CMD_LOAD,  32'h0000_0240, 32'h0,         4, 1'b1, 1'b0, 5};
        vecs[7]  = '{CMD_LOAD,  32'h0000_0040, 32'h0,         1, 1'b0, 1'b0, 1};
        vecs[8]  = '{CMD_LOAD,  32'h0000_0440, 32'h0,         1, 1'b1, 1'b0, 2};
        vecs[9]  = '{CMD_LOAD,  32'h0000_0040, 32'h0,         1, 1'b0, 1'b0, 1};
        vecs[10] = '{CMD_LOAD,  32'h0000_0240, 32'h0,         2, 1'b1, 1'b0, 3};
        vecs[11] = '{CMD_LOAD,  32'h0000_0044, 32'h0,         1, 1'b0, 1'b0, 1};
        vecs[12] = '{CMD_LOAD,  32'h0000_0440, 32'h0,         3, 1'b1, 1'b0, 4};
        vecs[13] = '{CMD_LOAD,  32'hFFF8_0204, 32'h0,         1, 1'b0, 1'b0, 1};

        ref_mem[17'h10] = 32'h11111111;
        ref_mem[17'h11] = 32'h22222222;

        // ---------------- reset ----------------
        rst          = 1'b1;
        pipe.mem_cmd = CMD_NONE;
        pipe.addr    = '0;
        pipe.wdata   = '0;
        sram_rdata   = '0;
        sram_ready   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset ready", 64'(pipe.ready), 64'd1);
        check("reset sram_re", 64'(sram_re), 64'd0);
        check("reset sram_we", 64'(sram_we), 64'd0);
        check("reset rdata", 64'(pipe.rdata), 64'd0);
        check("reset state", 64'(pipe.state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].wd, vecs[i].delay,
                   saw_re, saw_we, cycles);
            check($sformatf("vec%0d sram_re_seen", i), 64'(saw_re), 64'(vecs[i].exp_re));
            check($sformatf("vec%0d sram_we_seen", i), 64'(saw_we), 64'(vecs[i].exp_we));
            check($sformatf("vec%0d cycles", i), 64'(cycles), 64'(vecs[i].exp_cycles));
        end

        // ---------------- idle commands, stray sram_ready ----------------
        for (int i = 0; i < 10; i++) begin
            pipe.mem_cmd = (i < 5) ? 2'b00 : 2'b11;
            pipe.addr    = $urandom;
            pipe.wdata   = $urandom;
            sram_ready   = (i == 3);
            #1;
            check($sformatf("idle%0d ready", i), 64'(pipe.ready), 64'd1);
            check($sformatf("idle%0d sram_re", i), 64'(sram_re), 64'd0);
            check($sformatf("idle%0d sram_we", i), 64'(sram_we), 64'd0);
            @(negedge clk);
        end
        sram_ready   = 1'b0;
        pipe.mem_cmd = CMD_NONE;

        // ---------------- reset during FILL ----------------
        pipe.mem_cmd = CMD_LOAD;
        pipe.addr    = 32'h0000_0800;
        @(negedge clk);
        #1;
        check("rstfill sram_re before", 64'(sram_re), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rstfill sram_re", 64'(sram_re), 64'd0);
        check("rstfill ready", 64'(pipe.ready), 64'd1);
        check("rstfill state", 64'(pipe.state), 64'(IDLE));
        @(negedge clk);
        rst          = 1'b0;
        pipe.mem_cmd = CMD_NONE;
        @(negedge clk);

        run_op("refill 0x800", CMD_LOAD, 32'h0000_0800, 32'h0, 2, saw_re, saw_we, cycles);
        check("refill 0x800 sram_re_seen", 64'(saw_re), 64'd1);
        check("refill 0x800 cycles", 64'(cycles), 64'd3);
        run_op("refill 0x040", CMD_LOAD, 32'h0000_0040, 32'h0, 1, saw_re, saw_we, cycles);
        check("refill 0x040 sram_re_seen", 64'(saw_re), 64'd1);
        run_op("rehit 0x800", CMD_LOAD, 32'h0000_0804, 32'h0, 1, saw_re, saw_we, cycles);
        check("rehit 0x804 sram_re_seen", 64'(saw_re), 64'd0);

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
